// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button array front end.
package btn_pkg;

    // Per-channel debounce/hold state.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_LOCK = 2'd1,
        ST_HELD       = 2'd2,
        ST_REL_LOCK   = 2'd3
    } btn_state_e;

    // Width of a counter able to hold the largest of the three timing constants.
    function automatic int cnt_width(input int long_clks, input int repeat_clks, input int debounce_clks);
        int max_v;
        max_v = long_clks;
        if (repeat_clks > max_v) begin
            max_v = repeat_clks;
        end
        if (debounce_clks > max_v) begin
            max_v = debounce_clks;
        end
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, sampling flop, debounce FSM with lock-out
// windows, and the hold counter that produces long-press / auto-repeat pulses.
module btn_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CLKS = 1000,
    parameter int LONG_CLKS     = 50_000_000,
    parameter int REPEAT_CLKS   = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic pressed_o,
    output logic released_o,
    output logic long_o,
    output logic repeat_o
);

    localparam int              CW        = cnt_width(LONG_CLKS, REPEAT_CLKS, DEBOUNCE_CLKS);
    localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   DEB_LAST  = CW'(DEBOUNCE_CLKS - 1);
    localparam logic [CW-1:0]   LONG_LAST = CW'(LONG_CLKS - 1);
    localparam bit              REP_EN    = (REPEAT_CLKS > 0);
    localparam logic [CW-1:0]   REP_LAST  = REP_EN ? CW'(REPEAT_CLKS - 1) : CNT_ZERO;

    // Synchroniser chain; the last stage is the synchronised level.
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // Registered copy of the synchronised level; the FSM only looks at this.
    logic                   smp_q, smp_d;

    btn_state_e             state_q, state_d;
    logic [CW-1:0]          lock_q, lock_d;
    logic [CW-1:0]          hold_q, hold_d;
    logic                   long_done_q, long_done_d;

    logic                   level_q, level_d;
    logic                   pressed_q, pressed_d;
    logic                   released_q, released_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;

    // Hold-counter step results, applied by the FSM only while the button is held.
    logic [CW-1:0]          hold_nxt;
    logic                   long_done_nxt;
    logic                   long_hit;
    logic                   rep_hit;

    // Shift the raw level into the synchroniser and resample its last stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
        smp_d  = sync_q[SYNC_STAGES-1];
    end

    // Next hold-counter value: count to LONG, then (optionally) REPEAT periods; never wraps.
    always_comb begin
        hold_nxt      = hold_q;
        long_done_nxt = long_done_q;
        long_hit      = 1'b0;
        rep_hit       = 1'b0;
        if (!long_done_q) begin
            if (hold_q == LONG_LAST) begin
                long_hit      = 1'b1;
                long_done_nxt = 1'b1;
                hold_nxt      = CNT_ZERO;
            end else begin
                hold_nxt = hold_q + CNT_ONE;
            end
        end else if (REP_EN) begin
            if (hold_q == REP_LAST) begin
                rep_hit  = 1'b1;
                hold_nxt = CNT_ZERO;
            end else begin
                hold_nxt = hold_q + CNT_ONE;
            end
        end else begin
            // Repeat disabled: the counter parks once long_o has fired.
            hold_nxt = hold_q;
        end
    end

    // Debounce FSM next-state and output-pulse decode.
    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        pressed_d   = 1'b0;
        released_d  = 1'b0;
        long_d      = 1'b0;
        repeat_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (smp_q) begin
                    state_d     = ST_PRESS_LOCK;
                    pressed_d   = 1'b1;
                    lock_d      = CNT_ZERO;
                    hold_d      = CNT_ZERO;
                    long_done_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS_LOCK: begin
                if (lock_q == DEB_LAST) begin
                    lock_d = CNT_ZERO;
                    if (smp_q) begin
                        state_d     = ST_HELD;
                        hold_d      = hold_nxt;
                        long_done_d = long_done_nxt;
                        long_d      = long_hit;
                    end else begin
                        // Release wins over any hold-counter event on this cycle.
                        state_d     = ST_REL_LOCK;
                        released_d  = 1'b1;
                        hold_d      = CNT_ZERO;
                        long_done_d = 1'b0;
                    end
                end else begin
                    lock_d      = lock_q + CNT_ONE;
                    hold_d      = hold_nxt;
                    long_done_d = long_done_nxt;
                    long_d      = long_hit;
                end
            end
            ST_HELD: begin
                if (!smp_q) begin
                    state_d     = ST_REL_LOCK;
                    released_d  = 1'b1;
                    lock_d      = CNT_ZERO;
                    hold_d      = CNT_ZERO;
                    long_done_d = 1'b0;
                end else begin
                    hold_d      = hold_nxt;
                    long_done_d = long_done_nxt;
                    long_d      = long_hit;
                    repeat_d    = rep_hit;
                end
            end
            ST_REL_LOCK: begin
                // A level still high on the exit cycle is picked up by IDLE next cycle.
                if (lock_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    lock_d  = CNT_ZERO;
                end else begin
                    lock_d = lock_q + CNT_ONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                lock_d      = CNT_ZERO;
                hold_d      = CNT_ZERO;
                long_done_d = 1'b0;
            end
        endcase
    end

    // Debounced level follows the next state so it moves together with the pulses.
    always_comb begin
        level_d = (state_d == ST_PRESS_LOCK) || (state_d == ST_HELD);
    end

    // Channel state and registered outputs; reset drops any pending pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q      <= {SYNC_STAGES{1'b0}};
            smp_q       <= 1'b0;
            state_q     <= ST_IDLE;
            lock_q      <= CNT_ZERO;
            hold_q      <= CNT_ZERO;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            pressed_q   <= 1'b0;
            released_q  <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            smp_q       <= smp_d;
            state_q     <= state_d;
            lock_q      <= lock_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            pressed_q   <= pressed_d;
            released_q  <= released_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
        end
    end

    assign level_o    = level_q;
    assign pressed_o  = pressed_q;
    assign released_o = released_q;
    assign long_o     = long_q;
    assign repeat_o   = repeat_q;

endmodule

// File: rtl/btn_array_detector.sv
// Multi-channel push-button front end: NBTN independent debounce channels.
module btn_array_detector
    import btn_pkg::*;
#(
    parameter int NBTN          = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_CLKS = 1000,
    parameter int LONG_CLKS     = 50_000_000,
    parameter int REPEAT_CLKS   = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NBTN-1:0] btn_i,
    output logic [NBTN-1:0] level_o,
    output logic [NBTN-1:0] pressed_o,
    output logic [NBTN-1:0] released_o,
    output logic [NBTN-1:0] long_o,
    output logic [NBTN-1:0] repeat_o
);

    // Reject parameter sets the channel timing cannot honour.
    if (LONG_CLKS <= DEBOUNCE_CLKS) begin : g_bad_long
        $error("btn_array_detector: LONG_CLKS must exceed DEBOUNCE_CLKS");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("btn_array_detector: SYNC_STAGES must be at least 2");
    end
    if (NBTN < 1) begin : g_bad_nbtn
        $error("btn_array_detector: NBTN must be at least 1");
    end
    if (DEBOUNCE_CLKS < 1) begin : g_bad_deb
        $error("btn_array_detector: DEBOUNCE_CLKS must be at least 1");
    end

    for (genvar k = 0; k < NBTN; k++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES   (SYNC_STAGES),
            .DEBOUNCE_CLKS (DEBOUNCE_CLKS),
            .LONG_CLKS     (LONG_CLKS),
            .REPEAT_CLKS   (REPEAT_CLKS)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .btn_i      (btn_i[k]),
            .level_o    (level_o[k]),
            .pressed_o  (pressed_o[k]),
            .released_o (released_o[k]),
            .long_o     (long_o[k]),
            .repeat_o   (repeat_o[k])
        );
    end

endmodule
